if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Stall  input  1  from hazard detection; 1 = hold IF/ID and stop issuing new fetches.
REQ-005 Branch_Taken  input  1  from ID; 1 = redirect fetch to Branch_Target and flush IF/ID.
REQ-006 Branch_Target  input  32  redirect address; bits [1:0] forced to 00.
REQ-007 imem_req  output  1  fetch request.
REQ-008 imem_addr  output  32  fetch address; equals PC register.
REQ-009 imem_ready  input  1  memory accepts request; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 ID_Instr  output  32  IF/ID instruction register.
REQ-012 ID_PC4  output  32  IF/ID PC+4 register.
REQ-013 ID_Valid  output  1  IF/ID contents valid; 0 = bubble.

Function
REQ-014 Transfer T = imem_req && imem_ready at a rising edge; imem_req and imem_addr SHALL stay stable from assertion until T.
REQ-015 States: FETCH (imem_req=1), SKID (imem_req=0, one fetched word buffered), REDIRECT (imem_req=1, in-flight word to be discarded).
REQ-016 Branch_Taken SHALL be ignored while Stall=1; otherwise it has priority over all other events.
REQ-017 FETCH, T, Stall=0, no branch: ID_Instr<=imem_rdata, ID_PC4<=PC+4, ID_Valid<=1, PC<=PC+4; throughput one instruction per cycle when imem_ready=1.
REQ-018 FETCH, T, Stall=1: word and PC+4 into skid buffer, PC<=PC+4, IF/ID held, go SKID.
REQ-019 FETCH, no T, Stall=0, no branch: ID_Valid<=0, ID_Instr/ID_PC4 held.
REQ-020 Stall=1 in any state: ID_Instr, ID_PC4, ID_Valid held.
REQ-021 SKID, Stall=0, no branch: IF/ID<=skid contents, ID_Valid<=1, go FETCH.
REQ-022 Branch in FETCH with T: imem_rdata discarded, PC<=Branch_Target, ID_Valid<=0, stay FETCH.
REQ-023 Branch in FETCH without T: target saved, ID_Valid<=0, go REDIRECT.
REQ-024 REDIRECT: on T discard imem_rdata, PC<=saved target, go FETCH; a further branch overwrites saved target; ID_Valid<=0 throughout.
REQ-025 Branch in SKID: skid contents discarded, PC<=Branch_Target, ID_Valid<=0, go FETCH.
REQ-026 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0).

Reset
REQ-027 While reset=0: PC=RESET_PC, state FETCH, imem_req=0, ID_Instr=0, ID_PC4=0, ID_Valid=0, skid buffer and saved target cleared.
REQ-028 imem_req SHALL rise no earlier than the first rising edge after reset deasserts.
REQ-029 Reset asserted mid-transfer or in SKID/REDIRECT SHALL abandon the transfer with no IF/ID update.

Structure
REQ-030 Shared package if_pkg SHALL hold the state encoding (FETCH/SKID/REDIRECT), default RESET_PC and the 32-bit NOP constant (32'h0).
REQ-031 Single module; no sub-module is natural (PC, skid buffer, IF/ID register and FSM are one small unit).

Verification
REQ-032 Reset release, imem_ready=1 constantly, rdata=addr^32'hA5A5_A5A5 -> ID_PC4 = 4,8,12,... one per cycle, ID_Valid=1 from the 2nd cycle after release.
REQ-033 imem_ready=0 for 3 cycles at PC=0x10 -> imem_addr stable at 0x10, ID_Valid=0 for 3 cycles, then word for 0x10 with ID_PC4=0x14.
REQ-034 Stall=1 asserted in the cycle of T at PC=0x20 for 2 cycles -> IF/ID held, imem_req=0, then ID_PC4=0x24 with the buffered word, next fetch 0x24.
REQ-035 Branch_Taken=1, target 0x100, while imem_ready=0 at PC=0x40 -> imem_addr stays 0x40 until T, word discarded, next imem_addr=0x100, no ID_Valid=1 with ID_PC4=0x44.
REQ-036 Branch_Taken=1 with Stall=1 -> no redirect, PC and IF/ID unchanged.
REQ-037 Reset pulse while in SKID -> all outputs at reset values, first fetch at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage:
//   ifState_t        - fetch controller states
//   DEFAULT_RESET_PC - first fetch address after reset unless overridden
//   NOP              - instruction word loaded into IF/ID while in reset
//   pcPlus4          - sequential next-PC helper (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,   // request outstanding for the word at PC
        SKID     = 2'd1,   // one fetched word parked while ID is stalled
        REDIRECT = 2'd2    // request outstanding, returning word is stale
    } ifState_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // Plain 32-bit add: the carry out is dropped, so 0xFFFF_FFFC + 4 = 0.
    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: PC register, one-entry skid buffer, IF/ID pipeline
// register and a three-state fetch controller.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   reset          in   asynchronous, active-low reset
//   Stall          in   hold IF/ID and stop issuing new fetches
//   Branch_Taken   in   redirect fetch to Branch_Target and flush IF/ID
//   Branch_Target  in   redirect address (bits [1:0] treated as 00)
//   imem_req       out  fetch request
//   imem_addr      out  fetch address (the PC register)
//   imem_ready     in   memory accepts the request; imem_rdata valid same cycle
//   imem_rdata     in   fetched instruction word
//   ID_Instr       out  IF/ID instruction register
//   ID_PC4         out  IF/ID PC+4 register
//   ID_Valid       out  IF/ID contents valid (0 = bubble)
// -----------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ID_Instr,
    output logic [31:0] ID_PC4,
    output logic        ID_Valid
);

    ifState_t    state, stateNext;
    logic [31:0] pc, pcNext;
    logic        reqEn;
    logic [31:0] skidInstr, skidInstrNext;
    logic [31:0] skidPC4, skidPC4Next;
    logic [31:0] savedTarget, savedTargetNext;
    logic [31:0] idInstrNext, idPC4Next;
    logic        idValidNext;

    logic        xfer;
    logic        branch;
    logic [31:0] target;
    logic [31:0] pcInc;

    // reqEn keeps the request low until the first edge after reset release.
    assign imem_req  = reqEn && (state != SKID);
    assign imem_addr = pc;

    assign xfer   = imem_req && imem_ready;
    assign branch = Branch_Taken && !Stall;
    assign target = Branch_Target & ~32'h3;
    assign pcInc  = pcPlus4(pc);

    always_comb begin
        stateNext       = state;
        pcNext          = pc;
        skidInstrNext   = skidInstr;
        skidPC4Next     = skidPC4;
        savedTargetNext = savedTarget;
        idInstrNext     = ID_Instr;
        idPC4Next       = ID_PC4;
        idValidNext     = ID_Valid;

        case (state)
            FETCH: begin
                if (branch) begin
                    idValidNext = 1'b0;
                    // With nothing outstanding (word just taken, or no request
                    // yet) the PC can move now; otherwise the pending request
                    // must complete before the address may change.
                    if (xfer || !imem_req) begin
                        pcNext = target;
                    end else begin
                        savedTargetNext = target;
                        stateNext       = REDIRECT;
                    end
                end else if (xfer) begin
                    pcNext = pcInc;
                    if (Stall) begin
                        skidInstrNext = imem_rdata;
                        skidPC4Next   = pcInc;
                        stateNext     = SKID;
                    end else begin
                        idInstrNext = imem_rdata;
                        idPC4Next   = pcInc;
                        idValidNext = 1'b1;
                    end
                end else if (!Stall) begin
                    idValidNext = 1'b0;
                end
            end

            SKID: begin
                if (branch) begin
                    pcNext      = target;
                    idValidNext = 1'b0;
                    stateNext   = FETCH;
                end else if (!Stall) begin
                    idInstrNext = skidInstr;
                    idPC4Next   = skidPC4;
                    idValidNext = 1'b1;
                    stateNext   = FETCH;
                end
            end

            REDIRECT: begin
                if (!Stall) begin
                    idValidNext = 1'b0;
                end
                if (branch) begin
                    if (xfer) begin
                        pcNext    = target;
                        stateNext = FETCH;
                    end else begin
                        savedTargetNext = target;
                    end
                end else if (xfer) begin
                    pcNext    = savedTarget;
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            reqEn       <= 1'b0;
            skidInstr   <= NOP;
            skidPC4     <= 32'h0;
            savedTarget <= 32'h0;
            ID_Instr    <= NOP;
            ID_PC4      <= 32'h0;
            ID_Valid    <= 1'b0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            reqEn       <= 1'b1;
            skidInstr   <= skidInstrNext;
            skidPC4     <= skidPC4Next;
            savedTarget <= savedTargetNext;
            ID_Instr    <= idInstrNext;
            ID_PC4      <= idPC4Next;
            ID_Valid    <= idValidNext;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [31:0] Branch_Target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ID_Instr;
    logic [31:0] ID_PC4;
    logic        ID_Valid;

    int nCompared = 0;
    int nMismatched = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .Stall(Stall),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ID_Instr(ID_Instr), .ID_PC4(ID_PC4), .ID_Valid(ID_Valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    // A fetched word that cannot go to ID waits in a queue; a pending redirect
    // is a queue holding the target; the memory returns addr ^ K.
    typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } skidEnt_t;
    skidEnt_t    mSkid[$];
    logic [31:0] mRedir[$];
    logic [31:0] mPc;
    logic        mStarted;
    logic        mValid;
    logic [31:0] mInstr, mPc4;

    function automatic logic mReq();
        return mStarted && (mSkid.size() == 0);
    endfunction

    task automatic modelReset();
        mPc = 32'h0; mStarted = 1'b0; mSkid.delete(); mRedir.delete();
        mValid = 1'b0; mInstr = 32'h0; mPc4 = 32'h0;
    endtask

    task automatic modelStep(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
        logic        req, x;
        logic [31:0] t, nxt;
        skidEnt_t    e;
        req = mReq();
        x   = req && rdy;
        t   = {tgt[31:2], 2'b00};
        nxt = mPc + 32'd4;
        if (br && !st) begin
            mValid = 1'b0;
            mSkid.delete();
            mRedir.delete();
            if (x || !req) mPc = t;
            else mRedir.push_back(t);
        end else if (mSkid.size() != 0) begin
            if (!st) begin
                e = mSkid.pop_front();
                mInstr = e.instr; mPc4 = e.pc4; mValid = 1'b1;
            end
        end else if (x) begin
            if (mRedir.size() != 0) begin
                mPc = mRedir.pop_front();
            end else if (st) begin
                e.instr = mPc ^ K; e.pc4 = nxt;
                mSkid.push_back(e);
                mPc = nxt;
            end else begin
                mInstr = mPc ^ K; mPc4 = nxt; mValid = 1'b1;
                mPc = nxt;
            end
        end else if (!st) begin
            mValid = 1'b0;
        end
        mStarted = 1'b1;
    endtask

    // Called at a falling edge: apply inputs for one cycle, advance the model,
    // and return at the next falling edge.
    task automatic drive(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
        Stall = st; Branch_Taken = br; Branch_Target = tgt; imem_ready = rdy;
        imem_rdata = imem_addr ^ K;
        modelStep(st, br, tgt, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        modelReset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("FAIL reset_req: got %b want 0", imem_req); end
        nCompared++; if (imem_addr !== 32'h0) begin nMismatched++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        nCompared++; if (ID_Valid !== 1'b0) begin nMismatched++; $display("FAIL reset_valid: got %b want 0", ID_Valid); end
        nCompared++; if (ID_Instr !== 32'h0) begin nMismatched++; $display("FAIL reset_instr: got %h want 00000000", ID_Instr); end
        nCompared++; if (ID_PC4 !== 32'h0) begin nMismatched++; $display("FAIL reset_pc4: got %h want 00000000", ID_PC4); end
        reset = 1'b1;
        nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("FAIL release_req_early: got %b want 0", imem_req); end
    endtask

    task automatic test_stream();
        drive(0, 0, 0, 1);
        nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("FAIL stream_req_rise: got %b want 1", imem_req); end
        nCompared++; if (ID_Valid !== 1'b0) begin nMismatched++; $display("FAIL stream_first_valid: got %b want 0", ID_Valid); end
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 1);
            nCompared++; if (ID_Valid !== 1'b1) begin nMismatched++; $display("FAIL stream_valid[%0d]: got %b want 1", k, ID_Valid); end
            nCompared++; if (ID_PC4 !== 32'(4 * k)) begin nMismatched++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, ID_PC4, 32'(4 * k)); end
            nCompared++; if (ID_Instr !== (32'(4 * (k - 1)) ^ K)) begin nMismatched++; $display("FAIL stream_instr[%0d]: got %h want %h", k, ID_Instr, 32'(4 * (k - 1)) ^ K); end
        end
    endtask

    task automatic test_ready_wait();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0);
            nCompared++; if (imem_addr !== 32'h10) begin nMismatched++; $display("FAIL wait_addr[%0d]: got %h want 00000010", k, imem_addr); end
            nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("FAIL wait_req[%0d]: got %b want 1", k, imem_req); end
            nCompared++; if (ID_Valid !== 1'b0) begin nMismatched++; $display("FAIL wait_valid[%0d]: got %b want 0", k, ID_Valid); end
        end
        drive(0, 0, 0, 1);
        nCompared++; if (ID_Valid !== 1'b1) begin nMismatched++; $display("FAIL wait_done_valid: got %b want 1", ID_Valid); end
        nCompared++; if (ID_PC4 !== 32'h14) begin nMismatched++; $display("FAIL wait_done_pc4: got %h want 00000014", ID_PC4); end
        nCompared++; if (ID_Instr !== (32'h10 ^ K)) begin nMismatched++; $display("FAIL wait_done_instr: got %h want %h", ID_Instr, 32'h10 ^ K); end
        repeat (3) drive(0, 0, 0, 1);
    endtask

    task automatic test_stall();
        nCompared++; if (imem_addr !== 32'h20) begin nMismatched++; $display("FAIL stall_start_addr: got %h want 00000020", imem_addr); end
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 1);
            nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req); end
            nCompared++; if (ID_PC4 !== 32'h20) begin nMismatched++; $display("FAIL stall_hold_pc4[%0d]: got %h want 00000020", k, ID_PC4); end
            nCompared++; if (ID_Valid !== 1'b1) begin nMismatched++; $display("FAIL stall_hold_valid[%0d]: got %b want 1", k, ID_Valid); end
        end
        drive(0, 0, 0, 1);
        nCompared++; if (ID_PC4 !== 32'h24) begin nMismatched++; $display("FAIL skid_pc4: got %h want 00000024", ID_PC4); end
        nCompared++; if (ID_Instr !== (32'h20 ^ K)) begin nMismatched++; $display("FAIL skid_instr: got %h want %h", ID_Instr, 32'h20 ^ K); end
        nCompared++; if (ID_Valid !== 1'b1) begin nMismatched++; $display("FAIL skid_valid: got %b want 1", ID_Valid); end
        nCompared++; if (imem_addr !== 32'h24 || imem_req !== 1'b1) begin nMismatched++; $display("FAIL skid_next_fetch: got %h/%b want 00000024/1", imem_addr, imem_req); end
        repeat (7) drive(0, 0, 0, 1);
    endtask

    task automatic test_branch_wait();
        logic sawBad;
        sawBad = 1'b0;
        drive(0, 1, 32'h100, 0);
        nCompared++; if (imem_addr !== 32'h40) begin nMismatched++; $display("FAIL redir_hold_addr: got %h want 00000040", imem_addr); end
        nCompared++; if (ID_Valid !== 1'b0) begin nMismatched++; $display("FAIL redir_flush_valid: got %b want 0", ID_Valid); end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0);
            nCompared++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin nMismatched++; $display("FAIL redir_wait_addr[%0d]: got %h/%b want 00000040/1", k, imem_addr, imem_req); end
        end
        drive(0, 0, 0, 1);
        if (ID_Valid === 1'b1 && ID_PC4 === 32'h44) sawBad = 1'b1;
        nCompared++; if (imem_addr !== 32'h100) begin nMismatched++; $display("FAIL redir_target_addr: got %h want 00000100", imem_addr); end
        drive(0, 0, 0, 1);
        if (ID_Valid === 1'b1 && ID_PC4 === 32'h44) sawBad = 1'b1;
        nCompared++; if (ID_PC4 !== 32'h104 || ID_Valid !== 1'b1) begin nMismatched++; $display("FAIL redir_first_word: got %h/%b want 00000104/1", ID_PC4, ID_Valid); end
        nCompared++; if (sawBad !== 1'b0) begin nMismatched++; $display("FAIL redir_discard: got stale word 0x44 delivered=%b want 0", sawBad); end
    endtask

    task automatic test_branch_fetch();
        drive(0, 1, 32'h202, 1);
        nCompared++; if (imem_addr !== 32'h200) begin nMismatched++; $display("FAIL branch_align_addr: got %h want 00000200", imem_addr); end
        nCompared++; if (ID_Valid !== 1'b0) begin nMismatched++; $display("FAIL branch_flush_valid: got %b want 0", ID_Valid); end
        drive(0, 0, 0, 1);
        nCompared++; if (ID_PC4 !== 32'h204) begin nMismatched++; $display("FAIL branch_first_pc4: got %h want 00000204", ID_PC4); end
    endtask

    task automatic test_stall_branch();
        drive(1, 1, 32'h300, 0);
        nCompared++; if (imem_addr !== 32'h204) begin nMismatched++; $display("FAIL stallbr_addr: got %h want 00000204", imem_addr); end
        nCompared++; if (ID_Valid !== 1'b1 || ID_PC4 !== 32'h204) begin nMismatched++; $display("FAIL stallbr_ifid: got %b/%h want 1/00000204", ID_Valid, ID_PC4); end
        drive(1, 1, 32'h300, 1);
        nCompared++; if (imem_addr !== 32'h208) begin nMismatched++; $display("FAIL stallbr_skid_addr: got %h want 00000208", imem_addr); end
        drive(0, 0, 0, 1);
        nCompared++; if (ID_PC4 !== 32'h208 || ID_Valid !== 1'b1) begin nMismatched++; $display("FAIL stallbr_release: got %h/%b want 00000208/1", ID_PC4, ID_Valid); end
    endtask

    task automatic test_wrap();
        drive(0, 1, 32'hFFFF_FFFC, 1);
        drive(0, 0, 0, 1);
        nCompared++; if (ID_PC4 !== 32'h0) begin nMismatched++; $display("FAIL wrap_pc4: got %h want 00000000", ID_PC4); end
        nCompared++; if (imem_addr !== 32'h0) begin nMismatched++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
        nCompared++; if (ID_Instr !== (32'hFFFF_FFFC ^ K)) begin nMismatched++; $display("FAIL wrap_instr: got %h want %h", ID_Instr, 32'hFFFF_FFFC ^ K); end
    endtask

    task automatic test_skid_reset();
        drive(1, 0, 0, 1);
        nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("FAIL skidrst_in_skid: got req %b want 0", imem_req); end
        #2 reset = 1'b0;
        modelReset();
        #1;
        nCompared++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin nMismatched++; $display("FAIL skidrst_fetch: got %b/%h want 0/00000000", imem_req, imem_addr); end
        nCompared++; if (ID_Valid !== 1'b0 || ID_Instr !== 32'h0 || ID_PC4 !== 32'h0) begin nMismatched++; $display("FAIL skidrst_ifid: got %b/%h/%h want 0/0/0", ID_Valid, ID_Instr, ID_PC4); end
        @(posedge clk);
        @(negedge clk);
        Stall = 1'b0;
        reset = 1'b1;
        drive(0, 0, 0, 1);
        nCompared++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ID_Valid !== 1'b0) begin nMismatched++; $display("FAIL skidrst_restart: got %b/%h/%b want 1/00000000/0", imem_req, imem_addr, ID_Valid); end
        drive(0, 0, 0, 1);
        nCompared++; if (ID_PC4 !== 32'h4 || ID_Valid !== 1'b1) begin nMismatched++; $display("FAIL skidrst_first_word: got %h/%b want 00000004/1", ID_PC4, ID_Valid); end
    endtask

    task automatic test_random();
        logic st, br, rdy;
        logic [31:0] tgt;
        for (int i = 0; i < 600; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tgt = $urandom();
            drive(st, br, tgt, rdy);
            nCompared++; if (imem_req !== mReq()) begin nMismatched++; $display("FAIL rand_req[%0d]: got %b want %b", i, imem_req, mReq()); end
            nCompared++; if (imem_addr !== mPc) begin nMismatched++; $display("FAIL rand_addr[%0d]: got %h want %h", i, imem_addr, mPc); end
            nCompared++; if (ID_Valid !== mValid) begin nMismatched++; $display("FAIL rand_valid[%0d]: got %b want %b", i, ID_Valid, mValid); end
            if (mValid) begin
                nCompared++; if (ID_Instr !== mInstr || ID_PC4 !== mPc4) begin nMismatched++; $display("FAIL rand_ifid[%0d]: got %h/%h want %h/%h", i, ID_Instr, ID_PC4, mInstr, mPc4); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_wait();
        test_stall();
        test_branch_wait();
        test_branch_fetch();
        test_stall_branch();
        test_wrap();
        test_skid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
